// File: rtl/uart_imem_loader.sv
// UART boot loader: receives bytes on i_rx, packs them little-endian into 32-bit words and writes them sequentially to imem.
// Optional feature macro UART_LOADER_CKSUM_EN enables the modulo-256 byte checksum on o_cksum (tied to zero otherwise).
module uart_imem_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int IMEM_AW      = 12
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_prog,
    input  logic        i_rx,
    output logic [31:0] o_imem_din,
    output logic [31:0] o_imem_addr,
    output logic        o_imem_we,
    output logic        o_prog_ena,
    output logic [15:0] o_word_count,
    output logic        o_frame_err,
    output logic [7:0]  o_cksum
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t             r_state;
    logic               r_rx_meta;
    logic               r_rx_sync;
    logic               r_prog_ena;
    logic [CW-1:0]      r_cnt;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_shift;
    logic [7:0]         r_byte;
    logic               r_byte_valid;
    logic               r_frame_err;
    logic [1:0]         r_byte_idx;
    logic [23:0]        r_word;
    logic [IMEM_AW-1:0] r_addr;
    logic [IMEM_AW-1:0] r_imem_addr;
    logic [31:0]        r_imem_din;
    logic               r_imem_we;
    logic [15:0]        r_word_count;
    logic               w_prog_rise;

    // A new session starts on the cycle prog_ena goes high.
    assign w_prog_rise  = i_prog & ~r_prog_ena;
    assign o_imem_din   = r_imem_din;
    assign o_imem_addr  = 32'(r_imem_addr);
    assign o_imem_we    = r_imem_we;
    assign o_prog_ena   = r_prog_ena;
    assign o_word_count = r_word_count;
    assign o_frame_err  = r_frame_err;

    // rx synchroniser and registered programming enable
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rx_meta  <= 1'b1;
            r_rx_sync  <= 1'b1;
            r_prog_ena <= 1'b0;
        end else begin
            r_rx_meta  <= i_rx;
            r_rx_sync  <= r_rx_meta;
            r_prog_ena <= i_prog;
        end
    end

    // UART receive FSM; held in IDLE outside programming mode
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_bit_idx    <= 3'd0;
            r_shift      <= 8'h00;
            r_byte       <= 8'h00;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else if (!r_prog_ena) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_bit_idx    <= 3'd0;
            r_byte_valid <= 1'b0;
            if (w_prog_rise) r_frame_err <= 1'b0;
        end else begin
            r_byte_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (!r_rx_sync) r_state <= S_START;
                end
                S_START: begin
                    if (r_cnt == HALF_M1) begin
                        r_cnt     <= '0;
                        r_bit_idx <= 3'd0;
                        r_state   <= r_rx_sync ? S_IDLE : S_DATA;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DATA: begin
                    if (r_cnt == FULL_M1) begin
                        r_cnt              <= '0;
                        r_shift[r_bit_idx] <= r_rx_sync;
                        r_bit_idx          <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) r_state <= S_STOP;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_STOP: begin
                    if (r_cnt == FULL_M1) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                        if (r_rx_sync) begin
                            r_byte       <= r_shift;
                            r_byte_valid <= 1'b1;
                        end else begin
                            r_frame_err  <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Little-endian word assembly and sequential imem write
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_byte_idx   <= 2'd0;
            r_word       <= 24'h000000;
            r_addr       <= '0;
            r_imem_addr  <= '0;
            r_imem_din   <= 32'h00000000;
            r_imem_we    <= 1'b0;
            r_word_count <= 16'h0000;
        end else begin
            r_imem_we <= 1'b0;
            if (w_prog_rise) begin
                r_byte_idx   <= 2'd0;
                r_addr       <= '0;
                r_word_count <= 16'h0000;
            end else if (!r_prog_ena) begin
                r_byte_idx <= 2'd0;
            end else if (r_byte_valid) begin
                r_byte_idx <= r_byte_idx + 2'd1;
                case (r_byte_idx)
                    2'd0: r_word[7:0]   <= r_byte;
                    2'd1: r_word[15:8]  <= r_byte;
                    2'd2: r_word[23:16] <= r_byte;
                    default: begin
                        r_imem_din  <= {r_byte, r_word};
                        r_imem_addr <= r_addr;
                        r_imem_we   <= 1'b1;
                        r_addr      <= r_addr + IMEM_AW'(4);
                        if (r_word_count != 16'hFFFF) r_word_count <= r_word_count + 16'd1;
                    end
                endcase
            end
        end
    end

`ifdef UART_LOADER_CKSUM_EN
    logic [7:0] r_cksum;

    // Running sum of accepted bytes for the session
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cksum <= 8'h00;
        end else if (w_prog_rise) begin
            r_cksum <= 8'h00;
        end else if (r_byte_valid) begin
            r_cksum <= r_cksum + r_byte;
        end
    end

    assign o_cksum = r_cksum;
`else
    assign o_cksum = 8'h00;
`endif
endmodule
